game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter NUM_COLS, default 3: number of falling-letter columns.
REQ-002 SHALL have parameter SCORE_W, default 8: score width in bits.
REQ-003 SHALL have parameter START_LIVES, default 3: lives at game start, 1..15.
REQ-004 SHALL have parameter LEVEL_STEP, default 10: points per level increase.
REQ-005 SHALL have parameter MAX_LEVEL, default 7: level ceiling, 0..15.
REQ-006 SHALL have parameter BASE_TICKS, default 25000000: fall_tick period at level 0, in clocks.
REQ-007 SHALL have ports clock (in, 1, system clock) and reset_signal (in, 1, synchronous active-high reset).
REQ-008 SHALL have port start (in, 1): level-sensitive start request.
REQ-009 SHALL have port correct (in, NUM_COLS): per-column one-cycle pulse on a correct answer.
REQ-010 SHALL have port game_over (in, NUM_COLS): per-column one-cycle pulse when the letter reaches the bottom.
REQ-011 SHALL have port col_reset (out, NUM_COLS): per-column reset to the Column blocks.
REQ-012 SHALL have ports score (out, SCORE_W), lives (out, 4) and level (out, 4).
REQ-013 SHALL have ports fall_tick (out, 1; one-cycle drop strobe) and state (out, 2; 0=IDLE, 1=PLAY, 2=OVER).

Function
REQ-014 SHALL register all outputs; every response appears one clock after the causing input.
REQ-015 SHALL implement an FSM with transitions IDLE->PLAY on start=1, PLAY->OVER on loss, and OVER->IDLE on start=0 followed by start=1 (rising edge only).
REQ-016 SHALL, on entering PLAY, load score=0, level=0, lives=START_LIVES and zero the tick counter.
REQ-017 SHALL hold col_reset all-ones in IDLE and OVER; in PLAY, col_reset[i] SHALL be a one-cycle pulse following correct[i] or a life-consuming game_over[i].
REQ-018 SHALL add popcount(correct) to score per cycle in PLAY, saturating at 2^SCORE_W-1 with no wrap.
REQ-019 SHALL give game_over[i] priority over correct[i] when both are asserted in the same cycle; that column scores nothing.
REQ-020 SHALL set level = min(score / LEVEL_STEP, MAX_LEVEL), recomputed from the updated score.
REQ-021 SHALL pulse fall_tick once every (BASE_TICKS >> level) clocks in PLAY only; the floor period is 1 clock (pulse every cycle).
REQ-022 SHALL load a changed period at the next tick boundary; the in-flight count is not truncated.
REQ-023 SHALL ignore correct and game_over outside PLAY.
REQ-024 SHALL keep score and level frozen and readable in OVER until the next PLAY entry.
REQ-025 SHALL treat multiple game_over bits in one cycle as one lost life per asserted bit, with lives floored at 0.

Reset
REQ-026 SHALL, on reset_signal=1 at a clock edge, force state=IDLE, score=0, level=0, lives=START_LIVES, fall_tick=0, col_reset=all-ones and tick counter=0.
REQ-027 SHALL let reset_signal override start, correct and game_over in the same cycle, including mid-PLAY.

Configuration
REQ-028 SHALL, with macro GAME_LIVES_EN defined, decrement lives by popcount(game_over) and enter OVER only when lives reach 0; otherwise it resets the affected columns.
REQ-029 SHALL, with GAME_LIVES_EN undefined, enter OVER on any game_over bit, hold lives at START_LIVES constant, and exclude the lives logic from synthesis.

Verification
REQ-030 SHALL pass scenario V1: NUM_COLS=3, SCORE_W=4, BASE_TICKS=8; start=1, then correct=3'b111 for 6 cycles -> score 0->3->6->9->12->15->15 (saturated).
REQ-031 SHALL pass scenario V2: BASE_TICKS=8, LEVEL_STEP=2; score=2 -> level=1, next period is 4 clocks; score>=2*MAX_LEVEL -> period floors at 1 (fall_tick high every cycle).
REQ-032 SHALL pass scenario V3: correct=3'b010 and game_over=3'b010 in the same cycle -> score unchanged, col_reset=3'b010 next cycle, lives decremented by 1 (GAME_LIVES_EN).
REQ-033 SHALL pass scenario V4 with GAME_LIVES_EN defined: START_LIVES=2, game_over=3'b101 -> lives=0 and state=OVER next cycle; col_reset=3'b111 thereafter.
REQ-034 SHALL pass scenario V5 with GAME_LIVES_EN undefined: a single game_over=3'b001 -> state=OVER with lives still 2.
REQ-035 SHALL pass scenario V6: reset_signal pulsed mid-PLAY with score=9 -> state=IDLE, score=0, fall_tick=0; holding start=1 across OVER does not restart until start drops then rises.

Source files
------------

// File: rtl/game_controller.sv
// game_controller: falling-letter game FSM with score, level, fall_tick pacing and col_reset pulses.
// Define GAME_LIVES_EN for multi-life play; when undefined, any game_over pulse ends the game.
module game_controller #(
   parameter int NUM_COLS    = 3,
   parameter int SCORE_W     = 8,
   parameter int START_LIVES = 3,
   parameter int LEVEL_STEP  = 10,
   parameter int MAX_LEVEL   = 7,
   parameter int BASE_TICKS  = 25000000
) (
   input  logic                clock,
   input  logic                reset_signal,
   input  logic                start,
   input  logic [NUM_COLS-1:0] correct,
   input  logic [NUM_COLS-1:0] game_over,
   output logic [NUM_COLS-1:0] col_reset,
   output logic [SCORE_W-1:0]  score,
   output logic [3:0]          lives,
   output logic [3:0]          level,
   output logic                fall_tick,
   output logic [1:0]          state
);
   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_t;
   localparam int TW = $clog2(BASE_TICKS + 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   state_t cur, nxt;
   logic start_q, lost, tick, enter;
   logic [NUM_COLS-1:0] hit;
   logic [SCORE_W:0] sum;
   logic [SCORE_W-1:0] score_n;
   logic [3:0] level_n;
   logic [TW-1:0] cnt, per, per_n;
   int q;
   assign state = cur;
   assign enter = cur != PLAY && nxt == PLAY;
`ifdef GAME_LIVES_EN
   logic [3:0] lives_n;
   assign lives_n = (lives > 4'($countones(game_over))) ? lives - 4'($countones(game_over)) : 4'd0;
   assign lost = (|game_over) && lives_n == 4'd0;
   always_ff @(posedge clock)
      if (reset_signal || enter) lives <= 4'(START_LIVES);
      else if (cur == PLAY) lives <= lives_n;
`else
   assign lost = |game_over;
   assign lives = 4'(START_LIVES);
`endif
   // a column hit by game_over in the same cycle scores nothing
   always_comb begin
      hit = correct & ~game_over;
      sum = {1'b0, score} + (SCORE_W+1)'($countones(hit));
      score_n = (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
      q = 32'(score_n) / LEVEL_STEP;
      level_n = (q > MAX_LEVEL) ? 4'(MAX_LEVEL) : 4'(q);
      per_n = ((BASE_TICKS >> level_n) == 0) ? TW'(1) : TW'(BASE_TICKS >> level_n);
      tick = cnt == per - TW'(1);
      nxt = (cur == IDLE && start) ? PLAY :
            (cur == PLAY && lost) ? OVER :
            (cur == OVER && start && !start_q) ? IDLE : cur;
   end
   // the new period only takes effect when the running count completes
   always_ff @(posedge clock) begin
      if (reset_signal) begin
         cur       <= IDLE;
         start_q   <= 1'b0;
         score     <= '0;
         level     <= '0;
         fall_tick <= 1'b0;
         col_reset <= '1;
         cnt       <= '0;
         per       <= TW'(BASE_TICKS);
      end else begin
         cur       <= nxt;
         start_q   <= start;
         col_reset <= (nxt != PLAY) ? '1 : (cur == PLAY) ? (correct | game_over) : '0;
         fall_tick <= cur == PLAY && nxt == PLAY && tick;
         if (enter) begin
            score <= '0;
            level <= '0;
            cnt   <= '0;
            per   <= TW'(BASE_TICKS);
         end else if (cur == PLAY) begin
            score <= score_n;
            level <= level_n;
            cnt   <= tick ? '0 : cnt + TW'(1);
            per   <= tick ? per_n : per;
         end
      end
   end
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: driver queues hand-computed expectations; a negedge monitor pops and compares.
// Expectations follow GAME_LIVES_EN when the bench is built with that macro.
module tb_game_controller;
   typedef struct {
      logic [5:0] care;
      logic [1:0] st;
      logic [3:0] sc;
      logic [3:0] lv;
      logic [3:0] li;
      logic [2:0] cr;
      logic       ft;
   } exp_t;
   localparam logic [5:0] C_ST = 6'h01, C_SC = 6'h02, C_LV = 6'h04, C_LI = 6'h08, C_CR = 6'h10, C_FT = 6'h20, ALL = 6'h3F;
`ifdef GAME_LIVES_EN
   localparam logic [3:0] LO = 4'd0;
`else
   localparam logic [3:0] LO = 4'd2;
`endif
   logic clock = 1'b0;
   logic reset_signal, start, fall_tick;
   logic [2:0] correct, game_over, col_reset;
   logic [3:0] score, lives, level;
   logic [1:0] state;
   exp_t exp_q[$];
   string name_q[$];
   int checks = 0;
   int errors = 0;

   game_controller #(.NUM_COLS(3), .SCORE_W(4), .START_LIVES(2), .LEVEL_STEP(2), .MAX_LEVEL(7), .BASE_TICKS(8)) dut (
      .clock(clock), .reset_signal(reset_signal), .start(start), .correct(correct), .game_over(game_over),
      .col_reset(col_reset), .score(score), .lives(lives), .level(level), .fall_tick(fall_tick), .state(state));

   always #5 clock = ~clock;

   task automatic step(input logic r, input logic s, input logic [2:0] c, input logic [2:0] g, input string nm,
                       input logic [5:0] care, input logic [1:0] st, input logic [3:0] sc, input logic [3:0] lv,
                       input logic [3:0] li, input logic [2:0] cr, input logic ft);
      reset_signal = r;
      start = s;
      correct = c;
      game_over = g;
      @(posedge clock);
      #1;
      exp_q.push_back('{care, st, sc, lv, li, cr, ft});
      name_q.push_back(nm);
   endtask

   task automatic chk(input string n, input string f, input logic en, input logic [3:0] act, input logic [3:0] exp);
      if (en) begin
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0d expected %0d", n, f, act, exp);
         end
      end
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      string n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         chk(n, "state", e.care[0], {2'b0, state}, {2'b0, e.st});
         chk(n, "score", e.care[1], score, e.sc);
         chk(n, "level", e.care[2], level, e.lv);
         chk(n, "lives", e.care[3], lives, e.li);
         chk(n, "col_reset", e.care[4], {1'b0, col_reset}, {1'b0, e.cr});
         chk(n, "fall_tick", e.care[5], {3'b0, fall_tick}, {3'b0, e.ft});
      end
   end

   initial begin
      step(1, 0, 0, 0, "reset", ALL, 0, 0, 0, 2, 7, 0);
      step(0, 0, 7, 0, "idle_ignore", ALL, 0, 0, 0, 2, 7, 0);
      step(0, 1, 0, 0, "start", ALL, 1, 0, 0, 2, 0, 0);
      step(0, 1, 7, 0, "v1_3", ALL, 1, 3, 1, 2, 7, 0);
      step(0, 1, 7, 0, "v1_6", ALL, 1, 6, 3, 2, 7, 0);
      step(0, 1, 7, 0, "v1_9", ALL, 1, 9, 4, 2, 7, 0);
      step(0, 1, 7, 0, "v1_12", ALL, 1, 12, 6, 2, 7, 0);
      step(0, 1, 7, 0, "v1_15", ALL, 1, 15, 7, 2, 7, 0);
      step(0, 1, 7, 0, "v1_sat", ALL, 1, 15, 7, 2, 7, 0);
      step(0, 1, 0, 0, "v1_pre_tick", ALL, 1, 15, 7, 2, 0, 0);
      step(0, 1, 0, 0, "v1_tick8", ALL, 1, 15, 7, 2, 0, 1);
      step(0, 1, 0, 0, "v2_floor_a", ALL, 1, 15, 7, 2, 0, 1);
      step(0, 1, 0, 0, "v2_floor_b", ALL, 1, 15, 7, 2, 0, 1);
      step(1, 1, 7, 7, "reset_override", ALL, 0, 0, 0, 2, 7, 0);
      step(0, 1, 0, 0, "v2_start", ALL, 1, 0, 0, 2, 0, 0);
      step(0, 1, 2, 0, "v2_c1", ALL, 1, 1, 0, 2, 2, 0);
      step(0, 1, 2, 0, "v2_c2", ALL, 1, 2, 1, 2, 2, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, "v2_inflight", ALL, 1, 2, 1, 2, 0, 0);
      step(0, 1, 0, 0, "v2_tick8", ALL, 1, 2, 1, 2, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "v2_wait4", ALL, 1, 2, 1, 2, 0, 0);
      step(0, 1, 0, 0, "v2_tick4", ALL, 1, 2, 1, 2, 0, 1);
`ifdef GAME_LIVES_EN
      step(0, 1, 2, 2, "v3", ALL, 1, 2, 1, 1, 2, 0);
      step(0, 1, 0, 5, "v4", ALL, 2, 2, 1, 0, 7, 0);
`else
      step(0, 1, 2, 2, "v3", ALL, 2, 2, 1, 2, 7, 0);
`endif
      step(0, 1, 7, 0, "over_hold", ALL, 2, 2, 1, LO, 7, 0);
      step(0, 1, 0, 0, "over_hold2", ALL, 2, 2, 1, LO, 7, 0);
      step(0, 0, 0, 0, "over_drop", ALL, 2, 2, 1, LO, 7, 0);
      step(0, 1, 0, 0, "over_rise", ALL, 0, 2, 1, LO, 7, 0);
      step(0, 1, 0, 0, "replay", ALL, 1, 0, 0, 2, 0, 0);
`ifdef GAME_LIVES_EN
      step(0, 1, 0, 1, "v5", ALL, 1, 0, 0, 1, 1, 0);
`else
      step(0, 1, 0, 1, "v5", ALL, 2, 0, 0, 2, 7, 0);
      step(0, 0, 0, 0, "v5_drop", C_ST, 2, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, "v5_rise", C_ST, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, "v5_replay", ALL, 1, 0, 0, 2, 0, 0);
`endif
      step(0, 1, 7, 0, "v6_3", C_ST | C_SC | C_LV | C_CR, 1, 3, 1, 0, 7, 0);
      step(0, 1, 7, 0, "v6_6", C_ST | C_SC | C_LV | C_CR, 1, 6, 3, 0, 7, 0);
      step(0, 1, 7, 0, "v6_9", C_ST | C_SC | C_LV | C_CR, 1, 9, 4, 0, 7, 0);
      step(1, 1, 7, 7, "v6_reset", ALL, 0, 0, 0, 2, 7, 0);
      step(0, 1, 0, 0, "v6_restart", ALL, 1, 0, 0, 2, 0, 0);
      correct = 0;
      game_over = 0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
